// File: rtl/ttt_cursor_ctrl.sv
// Tic-tac-toe cursor controller. Button edges move the cursor on the 3x3 grid and sel places marks.
// The drawn rectangle is shadowed at frame start. Define CURSOR_BLINK_EN to make the cursor blink.
module ttt_cursor_ctrl #(
    parameter logic [10:0] GRID_X0       = 11'd170,
    parameter logic [10:0] GRID_Y0       = 11'd90,
    parameter logic [10:0] CELL_W        = 11'd100,
    parameter logic [10:0] CELL_H        = 11'd100,
    parameter logic [11:0] CURSOR_COLOR  = 12'h0F0,
    parameter logic [11:0] BLOCKED_COLOR = 12'hF00,
    parameter int          BLOCK_FRAMES  = 30,
    parameter int          BLINK_FRAMES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic        frame_start,
    input  logic [8:0]  cell_taken,
    output logic [10:0] box_x,
    output logic [10:0] box_y,
    output logic [10:0] box_width,
    output logic [10:0] box_height,
    output logic [11:0] box_color,
    output logic        place_valid,
    output logic [3:0]  place_idx
);
    localparam int             BCW        = $clog2(BLOCK_FRAMES + 1);
    localparam logic [BCW-1:0] BLOCK_LOAD = BCW'(BLOCK_FRAMES);
    localparam logic [BCW-1:0] BLOCK_ONE  = BCW'(1);

    typedef enum logic {NORMAL = 1'b0, BLOCKED = 1'b1} state_t;

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    logic [4:0]     btn_s, btn_q, edge_q, edge_d;
    logic [1:0]     row_q, row_d, col_q, col_d;
    state_t         state_q, state_d;
    logic [BCW-1:0] blk_cnt_q, blk_cnt_d;
    logic           place_valid_q, place_valid_d;
    logic [3:0]     place_idx_q, place_idx_d, idx_s;
    logic [10:0]    box_x_q, box_x_d, box_y_q, box_y_d;
    logic [10:0]    box_w_q, box_w_d, box_h_q, box_h_d;
    logic [11:0]    box_color_q, box_color_d;
    logic           blank_s;

    // bit order doubles as priority: lowest set bit wins
    assign btn_s = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign idx_s = {2'b00, row_q} * 4'd3 + {2'b00, col_q};

`ifdef CURSOR_BLINK_EN
    localparam int KCW = $clog2(BLINK_FRAMES + 1);
    logic [KCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_q, blink_d;

    // blink phase flips every BLINK_FRAMES frame starts
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (blink_cnt_q == KCW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = {KCW{1'b0}};
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + KCW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // blink registers
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= {KCW{1'b0}};
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blank_s = blink_q & (state_q == NORMAL);
`else
    assign blank_s = 1'b0;
`endif

    // next-state: cursor motion, place/block decision, block countdown, shadow load
    always_comb begin
        edge_d        = btn_s & ~btn_q;
        row_d         = row_q;
        col_d         = col_q;
        state_d       = state_q;
        blk_cnt_d     = blk_cnt_q;
        place_valid_d = 1'b0;
        place_idx_d   = place_idx_q;
        box_x_d       = box_x_q;
        box_y_d       = box_y_q;
        box_w_d       = box_w_q;
        box_h_d       = box_h_q;
        box_color_d   = box_color_q;

        if (edge_q[0]) begin
            row_d = wrap_dec(row_q);
        end else if (edge_q[1]) begin
            row_d = wrap_inc(row_q);
        end else if (edge_q[2]) begin
            col_d = wrap_dec(col_q);
        end else if (edge_q[3]) begin
            col_d = wrap_inc(col_q);
        end else if (edge_q[4] && (state_q == NORMAL)) begin
            if (cell_taken[idx_s]) begin
                state_d   = BLOCKED;
                blk_cnt_d = BLOCK_LOAD;
            end else begin
                place_valid_d = 1'b1;
                place_idx_d   = idx_s;
            end
        end else begin
            row_d = row_q;
        end

        case (state_q)
            BLOCKED: begin
                if (frame_start) begin
                    if (blk_cnt_q <= BLOCK_ONE) begin
                        state_d   = NORMAL;
                        blk_cnt_d = {BCW{1'b0}};
                    end else begin
                        blk_cnt_d = blk_cnt_q - BLOCK_ONE;
                    end
                end else begin
                    blk_cnt_d = blk_cnt_q;
                end
            end
            default: ;
        endcase

        // shadow load uses the pre-update position and state
        if (frame_start) begin
            box_x_d     = GRID_X0 + 11'(col_q) * CELL_W;
            box_y_d     = GRID_Y0 + 11'(row_q) * CELL_H;
            box_w_d     = blank_s ? 11'd0 : CELL_W;
            box_h_d     = blank_s ? 11'd0 : CELL_H;
            box_color_d = (state_q == BLOCKED) ? BLOCKED_COLOR : CURSOR_COLOR;
        end else begin
            box_x_d = box_x_q;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q         <= 5'd0;
            edge_q        <= 5'd0;
            row_q         <= 2'd1;
            col_q         <= 2'd1;
            state_q       <= NORMAL;
            blk_cnt_q     <= {BCW{1'b0}};
            place_valid_q <= 1'b0;
            place_idx_q   <= 4'd0;
            box_x_q       <= GRID_X0 + CELL_W;
            box_y_q       <= GRID_Y0 + CELL_H;
            box_w_q       <= CELL_W;
            box_h_q       <= CELL_H;
            box_color_q   <= CURSOR_COLOR;
        end else begin
            btn_q         <= btn_s;
            edge_q        <= edge_d;
            row_q         <= row_d;
            col_q         <= col_d;
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            place_valid_q <= place_valid_d;
            place_idx_q   <= place_idx_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            box_w_q       <= box_w_d;
            box_h_q       <= box_h_d;
            box_color_q   <= box_color_d;
        end
    end

    assign box_x       = box_x_q;
    assign box_y       = box_y_q;
    assign box_width   = box_w_q;
    assign box_height  = box_h_q;
    assign box_color   = box_color_q;
    assign place_valid = place_valid_q;
    assign place_idx   = place_idx_q;
endmodule
